// File: rtl/acc_pkg.sv
// Shared types for the Tinsel accelerator path: network address, flit layout
// and message-size limits used by acc_msg_buffer and the accelerator itself.
`ifndef TinselMaxFlitsPerMsg
`define TinselMaxFlitsPerMsg 4
`endif

package acc_pkg;

  typedef struct packed {
    logic       acc;
    logic       host;
    logic [3:0] board_y;
    logic [3:0] board_x;
    logic [1:0] mbox_y;
    logic [1:0] mbox_x;
    logic [5:0] thread;
  } NetAddr;

  typedef struct packed {
    NetAddr      dest;
    logic [31:0] payload;
    logic        not_final_flit;
    logic        is_idle_token;
  } Flit;

  localparam int FLIT_BITS         = $bits(Flit);
  localparam int MAX_FLITS_PER_MSG = `TinselMaxFlitsPerMsg;

  function automatic logic is_final(input Flit f);
    return !f.not_final_flit;
  endfunction

endpackage

// File: rtl/acc_flit_ram.sv
// Flit storage for the message buffer: one synchronous write port and one
// combinational read port, clocked on the falling edge like the accelerator.
module acc_flit_ram #(
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4,
  parameter int WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [LOG_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [LOG_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/acc_msg_buffer.sv
// Store-and-forward flit buffer in front of the Tinsel accelerator: a message
// is released only once its final flit is resident. Optional counters: ACC_MSG_BUF_STATS_EN.
module acc_msg_buffer
  import acc_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  Flit                in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output Flit                out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG_DEPTH:0] occupancy,
  output logic [LOG_DEPTH:0] complete_msgs
`ifdef ACC_MSG_BUF_STATS_EN
  ,
  output logic [31:0]        stat_flits_in,
  output logic [31:0]        stat_msgs_in,
  output logic [31:0]        stat_idle_in
`endif
);

  localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] CNT_ONE   = (LOG_DEPTH+1)'(1);

  // A full buffer with no complete message would deadlock, so the array must
  // hold at least one maximum-length message.
  if ((DEPTH < MAX_FLITS_PER_MSG) || ((DEPTH & (DEPTH - 1)) != 0) ||
      ((1 << LOG_DEPTH) != DEPTH)) begin : g_bad_depth
    $error("acc_msg_buffer: DEPTH must be a power of two, equal 2**LOG_DEPTH and hold a full message");
  end

  logic [LOG_DEPTH:0]   wr_ptr;
  logic [LOG_DEPTH:0]   rd_ptr;
  logic [LOG_DEPTH:0]   msg_cnt;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 msg_in;
  logic                 msg_out;
  logic [FLIT_BITS-1:0] rd_vec;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign occupancy     = wr_ptr - rd_ptr;
  assign full          = (occupancy == DEPTH_CNT);
  assign in_ready      = !full;
  assign out_valid     = (msg_cnt != '0);
  assign complete_msgs = msg_cnt;
  assign out_data      = Flit'(rd_vec);

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign msg_in  = push && is_final(in_data);
  assign msg_out = pop && is_final(out_data);

  acc_flit_ram #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH),
    .WIDTH     (FLIT_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[LOG_DEPTH-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr[LOG_DEPTH-1:0]),
    .rd_data (rd_vec)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      msg_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CNT_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_ONE;
      end
      case ({msg_in, msg_out})
        2'b10:   msg_cnt <= msg_cnt + CNT_ONE;
        2'b01:   msg_cnt <= msg_cnt - CNT_ONE;
        default: msg_cnt <= msg_cnt;
      endcase
    end
  end

`ifdef ACC_MSG_BUF_STATS_EN
  always_ff @(negedge clk) begin
    if (rst) begin
      stat_flits_in <= '0;
      stat_msgs_in  <= '0;
      stat_idle_in  <= '0;
    end else if (push) begin
      stat_flits_in <= stat_flits_in + 32'd1;
      if (is_final(in_data)) begin
        stat_msgs_in <= stat_msgs_in + 32'd1;
      end
      if (in_data.is_idle_token) begin
        stat_idle_in <= stat_idle_in + 32'd1;
      end
    end
  end
`endif

  a_full_needs_msg : assert property (
    @(negedge clk) disable iff (rst) !(full && (msg_cnt == '0))
  ) else $error("acc_msg_buffer: buffer full with no complete message");

endmodule
